seq_shift_add_multiplier: RTL and testbench

//   Parametrised iterative shift-add multiplier; successor to the 4x4 combinational array multiplier.

---
 rtl/seq_shift_add_multiplier_if.sv | 25 ++
 rtl/seq_shift_add_multiplier.sv | 105 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-add multiplier.
// in_* : source -> multiplier, out_* : multiplier -> sink; busy is status only.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: one adder, WIDTH iterations plus a sign-fix cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends on ready, and in_ready is high only in IDLE, out_valid only in DONE.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  seq_shift_add_multiplier_if.slave bus,
  output logic [1:0]                state_o
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH:0]  a_q, a_d;
  logic [WIDTH:0]  b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   p_q, p_d;

  // Operands widened by one bit so |-2^(W-1)| is representable as a magnitude.
  logic [WIDTH:0]  a_ext, b_ext, a_mag, b_mag;
  logic            a_neg, b_neg;

  always_comb begin
    a_neg = bus.in_signed & bus.in_a[WIDTH-1];
    b_neg = bus.in_signed & bus.in_b[WIDTH-1];
    a_ext = {a_neg, bus.in_a};
    b_ext = {b_neg, bus.in_b};
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Magnitudes never exceed 2^(2W-2) or (2^W-1)^2, so 2W bits hold every partial sum.
        if (b_q[cnt_q]) acc_d = acc_q + (PW'(a_q) << cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        p_d     = neg_q ? -acc_q : acc_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY) || (state_q == FIX);
  assign bus.out_p     = p_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for the shift-add multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_multiplier;
  logic clk;
  logic rst;
  logic [1:0] state4, state8;
  int errors = 0;
  int checks = 0;

  seq_shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
  seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .state_o(state4)
  );
  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .state_o(state8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Called #1 after a rising edge with dut4 in IDLE; returns the same way with dut4 back in IDLE.
  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp_p, input string tag, input int hold);
    bus4.in_valid  = 1'b1;
    bus4.in_signed = s;
    bus4.in_a      = a;
    bus4.in_b      = b;
    @(posedge clk); #1;
    bus4.in_valid  = 1'b0;
    bus4.in_signed = ~s;
    bus4.in_a      = 4'($urandom_range(0, 15));
    bus4.in_b      = 4'($urandom_range(0, 15));
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_busy"}, 16'(bus4.busy), 16'd1);
      chk({tag, "_nv"}, 16'(bus4.out_valid), 16'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 16'(bus4.out_valid), 16'd1);
    chk({tag, "_p"}, 16'(bus4.out_p), 16'(exp_p));
    chk({tag, "_busy0"}, 16'(bus4.busy), 16'd0);
    chk({tag, "_inrdy0"}, 16'(bus4.in_ready), 16'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_p"}, 16'(bus4.out_p), 16'(exp_p));
      chk({tag, "_hold_v"}, 16'(bus4.out_valid), 16'd1);
      chk({tag, "_hold_rdy"}, 16'(bus4.in_ready), 16'd0);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    chk({tag, "_drop"}, 16'(bus4.out_valid), 16'd0);
    chk({tag, "_idle"}, 16'(bus4.in_ready), 16'd1);
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp_p, input string tag);
    bus8.in_valid  = 1'b1;
    bus8.in_signed = s;
    bus8.in_a      = a;
    bus8.in_b      = b;
    @(posedge clk); #1;
    bus8.in_valid  = 1'b0;
    bus8.in_a      = 8'($urandom_range(0, 255));
    bus8.in_b      = 8'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) begin
      chk({tag, "_nv"}, 16'(bus8.out_valid), 16'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 16'(bus8.out_valid), 16'd1);
    chk({tag, "_p"}, bus8.out_p, exp_p);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk({tag, "_idle"}, 16'(bus8.in_ready), 16'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int         ia, ib, ip;

    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_signed = 1'b0; bus4.in_a = '0; bus4.in_b = '0;
    bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_signed = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
    bus8.out_ready = 1'b0;
    #2;
    chk("rst_valid", 16'(bus4.out_valid), 16'd0);
    chk("rst_busy", 16'(bus4.busy), 16'd0);
    chk("rst_inrdy", 16'(bus4.in_ready), 16'd1);
    chk("rst_p", 16'(bus4.out_p), 16'd0);
    chk("rst_state", 16'(state4), 16'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    op4(1'b0, 4'd15, 4'd15, 8'hE1, "u15x15", 0);
    op4(1'b1, 4'h8, 4'h8, 8'h40, "sm8xm8", 0);
    op4(1'b1, 4'hD, 4'h5, 8'hF1, "sm3x5", 0);
    op4(1'b0, 4'd0, 4'd13, 8'h00, "u0x13", 0);
    op4(1'b1, 4'h8, 4'h7, 8'hC8, "sm8x7", 0);
    op4(1'b0, 4'd9, 4'd6, 8'h36, "bp9x6", 10);

    // Abort mid-BUSY; out_p currently holds 0x36 so the clear is visible.
    bus4.in_valid = 1'b1; bus4.in_signed = 1'b0; bus4.in_a = 4'd7; bus4.in_b = 4'd7;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_busy", 16'(bus4.busy), 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(bus4.out_valid), 16'd0);
    chk("mid_rst_busy", 16'(bus4.busy), 16'd0);
    chk("mid_rst_inrdy", 16'(bus4.in_ready), 16'd1);
    chk("mid_rst_p", 16'(bus4.out_p), 16'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 16'(state4), 16'd0);
    op4(1'b0, 4'd3, 4'd4, 8'h0C, "u3x4", 0);

    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u255x255");
    op8(1'b1, 8'h80, 8'h7F, 16'hC080, "sm128x127");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "sm128xm128");

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        ia = int'($signed(ra));
        ib = int'($signed(rb));
      end else begin
        ia = int'(ra);
        ib = int'(rb);
      end
      ip = ia * ib;
      op8(rs, ra, rb, ip[15:0], "rand8");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
